// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: memory pipeline stage (loads, stores, pass-through) driving a single memory controller.
// Define MEM_STORE_BUF_EN to post stores into a SB_DEPTH-entry buffer that drains when the stage is idle.
module mem_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int SB_DEPTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              in_valid,
  input  logic              forward,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [6:0]        ins_type,
  input  logic [2:0]        ins_details,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_val,
  output logic              in_ready,
  output logic [1:0]        memctl_op,
  output logic [1:0]        memctl_len,
  output logic [DATA_W-1:0] memctl_addr,
  output logic [DATA_W-1:0] memctl_data,
  input  logic              memctl_fin,
  input  logic [DATA_W-1:0] memctl_out,
  output logic              out_valid,
  output logic              output_forward,
  output logic [REG_AW-1:0] forward_rd_addr,
  output logic [DATA_W-1:0] forward_rd_val,
  output logic [REG_AW-1:0] output_rd_addr,
  output logic [DATA_W-1:0] output_rd_val,
  output logic [6:0]        output_ins_type,
  output logic [2:0]        stall
);
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_SAVE = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [1:0] MEM_NOP = 2'd0, MEM_LOAD = 2'd1, MEM_SAVE = 2'd2;
  localparam logic [2:0] STALL_MEM = 3'b010;
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d, len_q, len_d;
  logic [DATA_W-1:0] addr_q, addr_d, data_q, data_d, pend_data_q, pend_data_d;
  logic [DATA_W-1:0] frd_val_q, frd_val_d, ord_val_q, ord_val_d, rdata, ld_res;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d, frd_addr_q, frd_addr_d, ord_addr_q, ord_addr_d;
  logic [2:0] ld_fn_q, ld_fn_d;
  logic [6:0] oins_q, oins_d;
  logic out_valid_q, out_valid_d, ofwd_q, ofwd_d, fin_pend_q, fin_pend_d;
  logic is_load, is_save, mem_ins, ld_ok, st_ok, fin, sb_empty, sb_full;
  assign is_load = ins_type == OP_LOAD;
  assign is_save = ins_type == OP_SAVE;
  assign mem_ins = is_load || is_save;
  assign ld_ok = ins_details inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  assign st_ok = ins_details <= 3'd2;
  // A completion seen while frozen is replayed, with its data, once rdy_in returns
  assign fin = rdy_in && (memctl_fin || fin_pend_q);
  assign rdata = fin_pend_q ? pend_data_q : memctl_out;
  assign ld_res = (ld_fn_q == 3'd0) ? {{(DATA_W-8){rdata[7]}}, rdata[7:0]} :
                  (ld_fn_q == 3'd1) ? {{(DATA_W-16){rdata[15]}}, rdata[15:0]} :
                  (ld_fn_q == 3'd4) ? {{(DATA_W-8){1'b0}}, rdata[7:0]} :
                  (ld_fn_q == 3'd5) ? {{(DATA_W-16){1'b0}}, rdata[15:0]} : rdata;
  assign in_ready = state_q == IDLE && !(is_load && !sb_empty) && !(is_save && sb_full);
  assign stall = (in_valid && !in_ready) ? STALL_MEM : 3'd0;
`ifdef MEM_STORE_BUF_EN
  localparam int PW = $clog2(SB_DEPTH);
  logic [DATA_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
  logic [1:0] sb_len_q [SB_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic push, pop;
  assign push = rdy_in && in_valid && in_ready && is_save && st_ok;
  assign pop = state_q == DRAIN && fin;
  assign sb_empty = cnt_q == '0;
  assign sb_full = cnt_q == (PW+1)'(SB_DEPTH);
  always_comb begin
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      if (push) begin
        sb_addr_q[wp_q] <= mem_addr;
        sb_data_q[wp_q] <= mem_val;
        sb_len_q[wp_q] <= ins_details[1:0];
      end
    end
  end
`else
  assign sb_empty = 1'b1;
  assign sb_full = SB_DEPTH < 2;
`endif
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    len_d = len_q;
    addr_d = addr_q;
    data_d = data_q;
    ld_rd_d = ld_rd_q;
    ld_fn_d = ld_fn_q;
    out_valid_d = out_valid_q;
    ofwd_d = ofwd_q;
    frd_addr_d = frd_addr_q;
    frd_val_d = frd_val_q;
    ord_addr_d = ord_addr_q;
    ord_val_d = ord_val_q;
    oins_d = oins_q;
    fin_pend_d = rdy_in ? 1'b0 : (fin_pend_q || (memctl_fin && state_q != IDLE));
    pend_data_d = (!rdy_in && memctl_fin && !fin_pend_q) ? memctl_out : pend_data_q;
    if (rdy_in) begin
      out_valid_d = 1'b0;
      ofwd_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (is_load && ld_ok) begin
              state_d = LOAD_WAIT;
              op_d = MEM_LOAD;
              len_d = ins_details[1:0];
              addr_d = mem_addr;
              data_d = '0;
              ld_rd_d = rd_addr;
              ld_fn_d = ins_details;
            end
`ifndef MEM_STORE_BUF_EN
            else if (is_save && st_ok) begin
              state_d = STORE_WAIT;
              op_d = MEM_SAVE;
              len_d = ins_details[1:0];
              addr_d = mem_addr;
              data_d = mem_val;
            end
`endif
            else begin
              out_valid_d = 1'b1;
              oins_d = ins_type;
              ofwd_d = !mem_ins && forward;
              ord_addr_d = mem_ins ? '0 : rd_addr;
              ord_val_d = mem_ins ? '0 : rd_val;
              frd_addr_d = mem_ins ? frd_addr_q : rd_addr;
              frd_val_d = mem_ins ? frd_val_q : rd_val;
            end
          end
`ifdef MEM_STORE_BUF_EN
          else if (!sb_empty) begin
            state_d = DRAIN;
            op_d = MEM_SAVE;
            len_d = sb_len_q[rp_q];
            addr_d = sb_addr_q[rp_q];
            data_d = sb_data_q[rp_q];
          end
`endif
        end
        LOAD_WAIT: begin
          if (fin) begin
            state_d = IDLE;
            op_d = MEM_NOP;
            out_valid_d = 1'b1;
            ofwd_d = 1'b1;
            oins_d = OP_LOAD;
            ord_addr_d = ld_rd_q;
            ord_val_d = ld_res;
            frd_addr_d = ld_rd_q;
            frd_val_d = ld_res;
          end
        end
        STORE_WAIT: begin
          if (fin) begin
            state_d = IDLE;
            op_d = MEM_NOP;
            out_valid_d = 1'b1;
            oins_d = OP_SAVE;
            ord_addr_d = '0;
            ord_val_d = '0;
          end
        end
        default: begin
          if (fin) begin
            state_d = IDLE;
            op_d = MEM_NOP;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      op_q <= MEM_NOP;
      len_q <= 2'd0;
      addr_q <= '0;
      data_q <= '0;
      ld_rd_q <= '0;
      ld_fn_q <= '0;
      out_valid_q <= 1'b0;
      ofwd_q <= 1'b0;
      frd_addr_q <= '0;
      frd_val_q <= '0;
      ord_addr_q <= '0;
      ord_val_q <= '0;
      oins_q <= OP_ADDI;
      fin_pend_q <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      len_q <= len_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ld_rd_q <= ld_rd_d;
      ld_fn_q <= ld_fn_d;
      out_valid_q <= out_valid_d;
      ofwd_q <= ofwd_d;
      frd_addr_q <= frd_addr_d;
      frd_val_q <= frd_val_d;
      ord_addr_q <= ord_addr_d;
      ord_val_q <= ord_val_d;
      oins_q <= oins_d;
      fin_pend_q <= fin_pend_d;
      pend_data_q <= pend_data_d;
    end
  end
  assign memctl_op = op_q;
  assign memctl_len = len_q;
  assign memctl_addr = addr_q;
  assign memctl_data = data_q;
  assign out_valid = out_valid_q;
  assign output_forward = ofwd_q;
  assign forward_rd_addr = frd_addr_q;
  assign forward_rd_val = frd_val_q;
  assign output_rd_addr = ord_addr_q;
  assign output_rd_val = ord_val_q;
  assign output_ins_type = oins_q;
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed self-checking bench for mem_stage_pipe (buffered-store test under MEM_STORE_BUF_EN).
module tb_mem_stage_pipe;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_SAVE = 7'b0100011, OP_ADDI = 7'b0010011;
  localparam logic [1:0] MEM_NOP = 2'd0, MEM_LOAD = 2'd1, MEM_SAVE = 2'd2;
  localparam logic [2:0] STALL_MEM = 3'b010;
  logic clk = 1'b0, rst_in, rdy_in, in_valid, forward, in_ready, memctl_fin, out_valid, output_forward;
  logic [4:0] rd_addr, forward_rd_addr, output_rd_addr;
  logic [31:0] rd_val, mem_addr, mem_val, memctl_addr, memctl_data, memctl_out, forward_rd_val, output_rd_val;
  logic [6:0] ins_type, output_ins_type;
  logic [2:0] ins_details, stall;
  logic [1:0] memctl_op, memctl_len;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_stage_pipe dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .in_valid(in_valid), .forward(forward),
    .rd_addr(rd_addr), .rd_val(rd_val), .ins_type(ins_type), .ins_details(ins_details),
    .mem_addr(mem_addr), .mem_val(mem_val), .in_ready(in_ready), .memctl_op(memctl_op),
    .memctl_len(memctl_len), .memctl_addr(memctl_addr), .memctl_data(memctl_data),
    .memctl_fin(memctl_fin), .memctl_out(memctl_out), .out_valid(out_valid),
    .output_forward(output_forward), .forward_rd_addr(forward_rd_addr),
    .forward_rd_val(forward_rd_val), .output_rd_addr(output_rd_addr),
    .output_rd_val(output_rd_val), .output_ins_type(output_ins_type), .stall(stall)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic issue(input logic [6:0] t, input logic [2:0] fn, input logic [4:0] rd, input logic [31:0] v,
                       input logic fw, input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    ins_type = t;
    ins_details = fn;
    rd_addr = rd;
    rd_val = v;
    forward = fw;
    mem_addr = a;
    mem_val = d;
  endtask
  task automatic run_load(input string tag, input logic [2:0] fn, input logic [1:0] len,
                          input logic [31:0] mout, input logic [31:0] exp);
    int stalls;
    step();
    issue(OP_LOAD, fn, 5'd3, 32'h0, 1'b0, 32'h100, 32'h0);
    step();
    issue(OP_ADDI, 3'd0, 5'd9, 32'h55, 1'b0, 32'h0, 32'h0);
    #1;
    check({tag, " op"}, memctl_op, MEM_LOAD);
    check({tag, " len"}, memctl_len, len);
    check({tag, " addr"}, memctl_addr, 32'h100);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      stalls += (stall == STALL_MEM) ? 1 : 0;
      if (i == 2) begin
        check({tag, " addr held"}, memctl_addr, 32'h100);
        check({tag, " no early valid"}, out_valid, 1'b0);
        memctl_fin = 1'b1;
        memctl_out = mout;
      end
    end
    step();
    memctl_fin = 1'b0;
    memctl_out = 32'h0;
    in_valid = 1'b0;
    #1;
    check({tag, " stall cycles"}, stalls, 3);
    check({tag, " valid"}, out_valid, 1'b1);
    check({tag, " rd_val"}, output_rd_val, exp);
    check({tag, " rd_addr"}, output_rd_addr, 5'd3);
    check({tag, " fwd"}, output_forward, 1'b1);
    check({tag, " fwd_val"}, forward_rd_val, exp);
    check({tag, " op idle"}, memctl_op, MEM_NOP);
    step();
    #1;
    check({tag, " valid once"}, out_valid, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    in_valid = 1'b0;
    forward = 1'b0;
    rd_addr = '0;
    rd_val = '0;
    ins_type = '0;
    ins_details = '0;
    mem_addr = '0;
    mem_val = '0;
    memctl_fin = 1'b0;
    memctl_out = '0;
    repeat (2) step();
    rst_in = 1'b0;
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst op", memctl_op, MEM_NOP);
    check("rst len", memctl_len, 2'd0);
    check("rst ins_type", output_ins_type, OP_ADDI);
    check("rst in_ready", in_ready, 1'b1);
    check("rst stall", stall, 3'd0);
    check("rst rd_val", output_rd_val, 32'h0);
    check("rst fwd", output_forward, 1'b0);
    step();
    issue(OP_ADDI, 3'd0, 5'd5, 32'd7, 1'b1, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    #1;
    check("addi valid", out_valid, 1'b1);
    check("addi rd_addr", output_rd_addr, 5'd5);
    check("addi fwd_val", forward_rd_val, 32'd7);
    check("addi fwd", output_forward, 1'b1);
    check("addi op", memctl_op, MEM_NOP);
    check("addi ins_type", output_ins_type, OP_ADDI);
    step();
    issue(OP_ADDI, 3'd0, 5'd6, 32'h11, 1'b1, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    rdy_in = 1'b0;
    step();
    #1;
    check("freeze valid held", out_valid, 1'b1);
    check("freeze rd_addr", output_rd_addr, 5'd6);
    step();
    rdy_in = 1'b1;
    step();
    #1;
    check("unfreeze valid drop", out_valid, 1'b0);
    issue(OP_LOAD, 3'd3, 5'd4, 32'h99, 1'b1, 32'h80, 32'h0);
    step();
    in_valid = 1'b0;
    #1;
    check("bad ld valid", out_valid, 1'b1);
    check("bad ld rd_addr", output_rd_addr, 5'd0);
    check("bad ld fwd", output_forward, 1'b0);
    check("bad ld op", memctl_op, MEM_NOP);
    run_load("lb", 3'd0, 2'd0, 32'h0000_0080, 32'hFFFF_FF80);
    run_load("lhu", 3'd5, 2'd1, 32'h1234_8001, 32'h0000_8001);
    run_load("lh", 3'd1, 2'd1, 32'h1234_8001, 32'hFFFF_8001);
    step();
    issue(OP_LOAD, 3'd2, 5'd8, 32'h0, 1'b0, 32'h300, 32'h0);
    step();
    in_valid = 1'b0;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    memctl_fin = 1'b1;
    memctl_out = 32'hDEAD_BEEF;
    #1;
    check("rst mid op", memctl_op, MEM_NOP);
    check("rst mid valid", out_valid, 1'b0);
    step();
    memctl_fin = 1'b0;
    in_valid = 1'b1;
    ins_type = OP_LOAD;
    #1;
    check("late fin valid", out_valid, 1'b0);
    check("late fin op", memctl_op, MEM_NOP);
    check("late fin idle", in_ready, 1'b1);
    in_valid = 1'b0;
    step();
    issue(OP_LOAD, 3'd2, 5'd7, 32'h0, 1'b0, 32'h400, 32'h0);
    step();
    in_valid = 1'b0;
    rdy_in = 1'b0;
    step();
    memctl_fin = 1'b1;
    memctl_out = 32'h1357_9BDF;
    step();
    memctl_fin = 1'b0;
    memctl_out = 32'h0;
    #1;
    check("gap valid", out_valid, 1'b0);
    check("gap op held", memctl_op, MEM_LOAD);
    step();
    #1;
    check("gap still no valid", out_valid, 1'b0);
    step();
    rdy_in = 1'b1;
    #1;
    check("gap resume no valid", out_valid, 1'b0);
    step();
    #1;
    check("gap result valid", out_valid, 1'b1);
    check("gap result val", output_rd_val, 32'h1357_9BDF);
    check("gap result rd", output_rd_addr, 5'd7);
    step();
    #1;
    check("gap valid once", out_valid, 1'b0);
`ifdef MEM_STORE_BUF_EN
    issue(OP_SAVE, 3'd2, 5'd1, 32'h0, 1'b1, 32'h10, 32'hA1);
    step();
    issue(OP_SAVE, 3'd2, 5'd1, 32'h0, 1'b1, 32'h20, 32'hA2);
    #1;
    check("sb sw2 ready", in_ready, 1'b1);
    check("sb sw1 retired", out_valid, 1'b1);
    check("sb sw1 fwd", output_forward, 1'b0);
    check("sb sw1 rd", output_rd_addr, 5'd0);
    step();
    issue(OP_SAVE, 3'd2, 5'd1, 32'h0, 1'b1, 32'h30, 32'hA3);
    #1;
    check("sb full ready", in_ready, 1'b0);
    check("sb full stall", stall, STALL_MEM);
    check("sb sw2 retired", out_valid, 1'b1);
    step();
    #1;
    check("sb drain1 op", memctl_op, MEM_SAVE);
    check("sb drain1 addr", memctl_addr, 32'h10);
    check("sb drain1 data", memctl_data, 32'hA1);
    check("sb drain1 ready", in_ready, 1'b0);
    step();
    memctl_fin = 1'b1;
    #1;
    check("sb pre fin ready", in_ready, 1'b0);
    step();
    memctl_fin = 1'b0;
    #1;
    check("sb post fin ready", in_ready, 1'b1);
    step();
    issue(OP_LOAD, 3'd2, 5'd2, 32'h0, 1'b0, 32'h40, 32'h0);
    #1;
    check("sb load blocked", in_ready, 1'b0);
    check("sb sw3 retired", out_valid, 1'b1);
    step();
    #1;
    check("sb drain2 addr", memctl_addr, 32'h20);
    memctl_fin = 1'b1;
    step();
    memctl_fin = 1'b0;
    #1;
    check("sb load still blocked", in_ready, 1'b0);
    step();
    #1;
    check("sb drain3 addr", memctl_addr, 32'h30);
    memctl_fin = 1'b1;
    step();
    memctl_fin = 1'b0;
    #1;
    check("sb empty load ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    #1;
    check("sb load op", memctl_op, MEM_LOAD);
    check("sb load addr", memctl_addr, 32'h40);
    memctl_fin = 1'b1;
    memctl_out = 32'h42;
    step();
    memctl_fin = 1'b0;
    #1;
    check("sb load valid", out_valid, 1'b1);
    check("sb load val", output_rd_val, 32'h42);
`else
    issue(OP_SAVE, 3'd2, 5'd1, 32'h0, 1'b1, 32'h200, 32'hCAFE);
    step();
    in_valid = 1'b0;
    #1;
    check("sw op", memctl_op, MEM_SAVE);
    check("sw len", memctl_len, 2'd2);
    check("sw addr", memctl_addr, 32'h200);
    check("sw data", memctl_data, 32'hCAFE);
    check("sw wait valid", out_valid, 1'b0);
    step();
    memctl_fin = 1'b1;
    step();
    memctl_fin = 1'b0;
    #1;
    check("sw valid", out_valid, 1'b1);
    check("sw rd_addr", output_rd_addr, 5'd0);
    check("sw fwd", output_forward, 1'b0);
    check("sw op idle", memctl_op, MEM_NOP);
    check("sw ins_type", output_ins_type, OP_SAVE);
`endif
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL take parameter DATA_W, default 32, meaning data/address width (multiple of 16).
REQ-002 SHALL take parameter REG_AW, default 5, meaning register-index width.
REQ-003 SHALL take parameter SB_DEPTH, default 2, meaning posted-store buffer entries (power of two, ≥2).
REQ-004 SHALL have ports: clk_in in 1, the single clock; rst_in in 1, reset, synchronous active-high; rdy_in in 1, global enable, low freezes all state.
REQ-005 SHALL have upstream ports: in_valid in 1; forward in 1; rd_addr in REG_AW; rd_val in DATA_W; ins_type in 7; ins_details in 3; mem_addr in DATA_W; mem_val in DATA_W; in_ready out 1.
REQ-006 SHALL have controller ports: memctl_op out 2; memctl_len out 2; memctl_addr out DATA_W; memctl_data out DATA_W; memctl_fin in 1 (single-cycle completion pulse); memctl_out in DATA_W.
REQ-007 SHALL have registered result ports: out_valid out 1; output_forward out 1; forward_rd_addr out REG_AW; forward_rd_val out DATA_W; output_rd_addr out REG_AW; output_rd_val out DATA_W; output_ins_type out 7; stall out 3.

Function
REQ-008 SHALL run FSM IDLE, LOAD_WAIT, STORE_WAIT, DRAIN; accept an instruction in IDLE when in_valid and in_ready.
REQ-009 SHALL assert in_ready = 1 only in IDLE and (for LOAD) when no store is pending; stall = STALL_MEM whenever in_valid and not in_ready, else 0.
REQ-010 SHALL for non-memory ins_type pass rd_addr, rd_val, forward, ins_type to outputs one cycle after acceptance, memctl_op = MEM_NOP.
REQ-011 SHALL on LOAD latch address/len, enter LOAD_WAIT, hold memctl_op = MEM_LOAD and addr/len stable until memctl_fin; memctl_data = 0.
REQ-012 SHALL on memctl_fin in LOAD_WAIT register the result next cycle and return to IDLE: LB sign-extend bits [7:0]; LH sign-extend [15:0]; LW full; LBU/LHU zero-extend [7:0]/[15:0] to DATA_W; output_forward = 1, forward_rd_val = result.
REQ-013 SHALL treat undefined ins_details for LOAD or SAVE as NOP: no memory access, output_rd_addr = 0, output_forward = 0.
REQ-014 SHALL for SAVE (SB/SH/SW to BYTE/HALF/WORD) output output_forward = 0, output_rd_addr = 0.
REQ-015 SHALL drive out_valid high exactly one cycle per retired instruction; loads retire after fin, so minimum load latency = fin cycle + 1.
REQ-016 SHALL ignore memctl_fin outside LOAD_WAIT, STORE_WAIT, DRAIN.
REQ-017 SHALL, when rdy_in = 0, hold FSM, buffer, and all outputs unchanged; memctl_fin arriving during rdy_in = 0 is held pending and consumed on resumption.

Reset
REQ-018 SHALL on rst_in (synchronous, high) drive next cycle: state IDLE, buffer empty, memctl_op MEM_NOP, memctl_len MEM_BYTE, memctl_addr/data 0, out_valid 0, output_forward 0, all rd_addr/val 0, output_ins_type ADDI, stall 0, in_ready 1.
REQ-019 SHALL abandon any in-flight request on reset mid-operation; no result or store is retired.
REQ-020 SHALL give rst_in priority over rdy_in.

Configuration
REQ-021 SHALL, with MEM_STORE_BUF_EN defined, post SAVE into a SB_DEPTH FIFO (retire immediately, out_valid next cycle), drain oldest entry via DRAIN state when FSM idle, and refuse SAVE (in_ready = 0) when full.
REQ-022 SHALL, with MEM_STORE_BUF_EN defined, block LOAD acceptance until FIFO empty (drain-before-load); simultaneous FIFO write and drain-pop in the same cycle SHALL be legal at full.
REQ-023 SHALL, without MEM_STORE_BUF_EN, omit the FIFO: SAVE enters STORE_WAIT, holds MEM_SAVE until memctl_fin, then retires; SB_DEPTH unused.

Verification
REQ-024 SHALL check: LB at 0x100, memctl_out = 0x0000_0080, fin after 3 cycles -> output_rd_val = 0xFFFF_FF80, stall = STALL_MEM for 3 cycles, out_valid 1 cycle.
REQ-025 SHALL check: LHU, memctl_out = 0x1234_8001 -> output_rd_val = 0x0000_8001; LH same -> 0xFFFF_8001.
REQ-026 SHALL check: ADDI rd = 5, rd_val = 7, forward = 1 -> next cycle output_rd_addr = 5, forward_rd_val = 7, memctl_op = MEM_NOP.
REQ-027 SHALL check: with MEM_STORE_BUF_EN, SB_DEPTH = 2, three back-to-back SW with fin withheld -> third sees in_ready = 0 until first fin; then LW stalls until FIFO empty.
REQ-028 SHALL check: rst_in asserted during LOAD_WAIT, then a late fin -> no out_valid, memctl_op = MEM_NOP, state IDLE.
REQ-029 SHALL check: rdy_in low for 4 cycles during LOAD_WAIT with fin inside the gap -> result appears one cycle after rdy_in returns high, value unchanged.
